// File: rtl/psram_spi_target_if.sv
// SPI pin bundle and status outputs of the APS6404-style PSRAM target.
interface psram_spi_target_if;
  logic       spiclk;
  logic       mosi;
  logic       ce_;
  logic       miso;
  logic [7:0] cmd_q;
  logic [7:0] rst_count;
  logic       busy;

  modport master (output spiclk, mosi, ce_, input miso, cmd_q, rst_count, busy);
  modport slave  (input spiclk, mosi, ce_, output miso, cmd_q, rst_count, busy);
endinterface

// File: rtl/psram_spi_target.sv
// SPI mode-0 target emulating APS6404 PSRAM: READ/WRITE/READID/RSTEN+RST over a byte RAM.
// Optional: define PSRAM_SPI_TARGET_PAGEWRAP_EN for 1 KiB page-wrapping bursts.
module psram_spi_target #(
  parameter int unsigned   DEPTH_LOG2 = 12,
  parameter logic [7:0]    MFID       = 8'h0D,
  parameter logic [7:0]    KGD        = 8'h5D,
  parameter logic [47:0]   EID        = 48'h123456789ABC
) (
  input logic               sysclk,
  input logic               rst_n,
  psram_spi_target_if.slave bus
);
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA_WR, DATA_RD, ID_OUT, IGNORE} state_t;
  typedef enum logic [1:0] {MODE_WR, MODE_RD, MODE_ID} mode_t;

  localparam logic [63:0] ID_SEQ = {MFID, KGD, EID};

  logic [1:0]            clk_s, ce_s, mosi_s;
  logic                  clk_d;
  logic                  rise, fall, ce_hi, din;
  state_t                state;
  mode_t                 mode;
  logic [4:0]            bit_cnt;
  logic [7:0]            shreg, nxt_byte, out_byte, id_byte;
  logic [7:0]            rd_data, wr_data;
  logic [DEPTH_LOG2-1:0] addr, addr_inc;
  logic [2:0]            id_idx;
  logic                  wr_en, rsten, rst_armed;
  logic                  miso_q;
  logic [7:0]            cmd_q, rst_count;
  logic [7:0]            mem [0:(1<<DEPTH_LOG2)-1];

  // ce_ synchroniser resets high so the block comes out of reset deselected.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s  <= '0;
      ce_s   <= '1;
      mosi_s <= '0;
      clk_d  <= 1'b0;
    end else begin
      clk_s  <= {clk_s[0], bus.spiclk};
      ce_s   <= {ce_s[0], bus.ce_};
      mosi_s <= {mosi_s[0], bus.mosi};
      clk_d  <= clk_s[1];
    end
  end

  assign rise     = clk_s[1] & ~clk_d;
  assign fall     = ~clk_s[1] & clk_d;
  assign ce_hi    = ce_s[1];
  assign din      = mosi_s[1];
  assign nxt_byte = {shreg[6:0], din};
  assign id_byte  = ID_SEQ[{~id_idx, 3'b000} +: 8];
  assign out_byte = (state == ID_OUT) ? id_byte : rd_data;

`ifdef PSRAM_SPI_TARGET_PAGEWRAP_EN
  localparam int unsigned PAGE_BITS = (DEPTH_LOG2 > 10) ? 10 : DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PAGE_MASK = DEPTH_LOG2'((64'd1 << PAGE_BITS) - 64'd1);
  assign addr_inc = (addr & ~PAGE_MASK) | ((addr + DEPTH_LOG2'(1)) & PAGE_MASK);
`else
  assign addr_inc = addr + DEPTH_LOG2'(1);
`endif

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mode      <= MODE_WR;
      bit_cnt   <= '0;
      shreg     <= '0;
      addr      <= '0;
      id_idx    <= '0;
      wr_data   <= '0;
      wr_en     <= 1'b0;
      rsten     <= 1'b0;
      rst_armed <= 1'b0;
      miso_q    <= 1'b0;
      cmd_q     <= '0;
      rst_count <= '0;
    end else begin
      // A completed write byte commits even if ce_ rises right behind it.
      wr_en <= 1'b0;
      if (wr_en) addr <= addr_inc;
      if (ce_hi) begin
        state   <= IDLE;
        bit_cnt <= '0;
        shreg   <= '0;
        miso_q  <= 1'b0;
        if (rst_armed) begin
          rst_count <= rst_count + 8'd1;
          rsten     <= 1'b0;
          rst_armed <= 1'b0;
        end
      end else begin
        case (state)
          IDLE: begin
            state   <= CMD;
            bit_cnt <= '0;
          end
          CMD: if (rise) begin
            shreg   <= nxt_byte;
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd7) begin
              bit_cnt   <= '0;
              cmd_q     <= nxt_byte;
              rsten     <= (nxt_byte == 8'h66);
              rst_armed <= (nxt_byte == 8'h99) && rsten;
              state     <= ADDR;
              case (nxt_byte)
                8'h02:   mode  <= MODE_WR;
                8'h03:   mode  <= MODE_RD;
                8'h9F:   mode  <= MODE_ID;
                default: state <= IGNORE;
              endcase
            end
          end
          ADDR: if (rise) begin
            addr    <= {addr[DEPTH_LOG2-2:0], din};
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd23) begin
              bit_cnt <= '0;
              id_idx  <= '0;
              case (mode)
                MODE_WR: state <= DATA_WR;
                MODE_RD: state <= DATA_RD;
                default: state <= ID_OUT;
              endcase
            end
          end
          DATA_WR: if (rise) begin
            shreg   <= nxt_byte;
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd7) begin
              bit_cnt <= '0;
              wr_data <= nxt_byte;
              wr_en   <= 1'b1;
            end
          end
          // RAM output tracks addr continuously, so the next byte is ready one fall later.
          DATA_RD, ID_OUT: if (fall) begin
            if (bit_cnt == 5'd0) begin
              miso_q <= out_byte[7];
              shreg  <= {out_byte[6:0], 1'b0};
            end else begin
              miso_q <= shreg[7];
              shreg  <= {shreg[6:0], 1'b0};
            end
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd7) begin
              bit_cnt <= '0;
              if (state == ID_OUT) id_idx <= id_idx + 3'd1;
              else                 addr   <= addr_inc;
            end
          end
          IGNORE:  miso_q <= 1'b0;
          default: state  <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge sysclk) begin
    if (wr_en) mem[addr] <= wr_data;
    rd_data <= mem[addr];
  end

  assign bus.miso      = miso_q;
  assign bus.cmd_q     = cmd_q;
  assign bus.rst_count = rst_count;
  assign bus.busy      = ~ce_s[1];
endmodule

// File: tb/tb_psram_spi_target.sv
// Self-checking bench for psram_spi_target: vector table, corner sequences, random traffic vs a memory model.
module tb_psram_spi_target;
  localparam int unsigned HALF  = 80;
  localparam int unsigned DEPTH = 4096;
  localparam logic [63:0] ID_SEQ = 64'h0D5D123456789ABC;

  typedef struct {
    logic [7:0]  op;
    logic [23:0] addr;
    int unsigned n;
    logic [63:0] data;
    logic [7:0]  exp_cmd;
    logic [7:0]  exp_rcnt;
  } vec_t;

  logic sysclk = 1'b0;
  logic rst_n  = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [7:0]  ref_mem [DEPTH];
  bit          known   [DEPTH];
  bit          ref_rsten;
  int unsigned ref_rcnt;

  psram_spi_target_if bus();

  psram_spi_target #(
    .DEPTH_LOG2(12),
    .MFID(8'h0D),
    .KGD(8'h5D),
    .EID(48'h123456789ABC)
  ) dut (
    .sysclk(sysclk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 sysclk = ~sysclk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic int unsigned next_addr(input int unsigned a);
`ifdef PSRAM_SPI_TARGET_PAGEWRAP_EN
    return (a & 32'hC00) | ((a + 1) & 32'h3FF);
`else
    return (a + 1) % DEPTH;
`endif
  endfunction

  task automatic model_op(input logic [7:0] op);
    if (op == 8'h66) ref_rsten = 1'b1;
    else begin
      if (op == 8'h99 && ref_rsten) ref_rcnt = (ref_rcnt + 1) % 256;
      ref_rsten = 1'b0;
    end
  endtask

  task automatic xbit(input logic b, output logic r);
    bus.mosi = b;
    #(HALF);
    r = bus.miso;
    bus.spiclk = 1'b1;
    #(HALF);
    bus.spiclk = 1'b0;
  endtask

  task automatic xbyte(input logic [7:0] b, output logic [7:0] r);
    for (int i = 7; i >= 0; i--) xbit(b[i], r[i]);
  endtask

  task automatic cs_low();
    @(negedge sysclk);
    bus.ce_ = 1'b0;
    #(HALF);
  endtask

  task automatic cs_high();
    #(HALF);
    bus.ce_ = 1'b1;
    #(HALF);
  endtask

  task automatic send_addr(input logic [23:0] a);
    logic r;
    for (int i = 23; i >= 0; i--) xbit(a[i], r);
  endtask

  task automatic run_txn(input logic [7:0] op, input logic [23:0] a, input int unsigned n,
                         input logic [63:0] wdata, output logic [63:0] rdata);
    logic [7:0]  r;
    int unsigned p;
    rdata = '0;
    cs_low();
    check("busy_active", bus.busy, 1'b1);
    xbyte(op, r);
    if (op == 8'h02 || op == 8'h03 || op == 8'h9F) begin
      send_addr(a);
      for (int unsigned k = 0; k < n; k++) begin
        xbyte(wdata[63-8*k -: 8], r);
        rdata[63-8*k -: 8] = r;
      end
    end
    cs_high();
    model_op(op);
    if (op == 8'h02) begin
      p = a[11:0];
      for (int unsigned k = 0; k < n; k++) begin
        ref_mem[p] = wdata[63-8*k -: 8];
        known[p]   = 1'b1;
        p = next_addr(p);
      end
    end
  endtask

  vec_t        vecs [14];
  vec_t        v;
  logic [63:0] rd;
  logic [7:0]  rb, op;
  logic        rbit;
  int unsigned a, n, p, sel, last_wa;

  initial begin
`ifdef PSRAM_SPI_TARGET_PAGEWRAP_EN
    localparam logic [23:0] WA = 24'h0003FF;
    localparam logic [63:0] WD = 64'h3344000000000000;
    localparam logic [63:0] W2 = 64'h4400000000000000;
`else
    localparam logic [23:0] WA = 24'h000FFF;
    localparam logic [63:0] WD = 64'h1122000000000000;
    localparam logic [63:0] W2 = 64'h2200000000000000;
`endif
    vecs[0]  = '{8'h9F, 24'h000000, 8, ID_SEQ,                8'h9F, 8'd0};
    vecs[1]  = '{8'h02, 24'h000010, 2, 64'hA53C000000000000,  8'h02, 8'd0};
    vecs[2]  = '{8'h03, 24'h000010, 2, 64'hA53C000000000000,  8'h03, 8'd0};
    vecs[3]  = '{8'h66, 24'h000000, 0, 64'h0,                 8'h66, 8'd0};
    vecs[4]  = '{8'h99, 24'h000000, 0, 64'h0,                 8'h99, 8'd1};
    vecs[5]  = '{8'h99, 24'h000000, 0, 64'h0,                 8'h99, 8'd1};
    vecs[6]  = '{8'h66, 24'h000000, 0, 64'h0,                 8'h66, 8'd1};
    vecs[7]  = '{8'h02, 24'h000000, 0, 64'h0,                 8'h02, 8'd1};
    vecs[8]  = '{8'h99, 24'h000000, 0, 64'h0,                 8'h99, 8'd1};
    vecs[9]  = '{8'h02, WA,         2, WD,                    8'h02, 8'd1};
    vecs[10] = '{8'h03, WA,         2, WD,                    8'h03, 8'd1};
    vecs[11] = '{8'h03, 24'h000000, 1, W2,                    8'h03, 8'd1};
    vecs[12] = '{8'h03, 24'h000011, 1, 64'h3C00000000000000,  8'h03, 8'd1};
    vecs[13] = '{8'h03, 24'hABC010, 1, 64'hA500000000000000,  8'h03, 8'd1};

    ref_rsten = 1'b0;
    ref_rcnt  = 0;
    last_wa   = 0;
    foreach (known[i]) known[i] = 1'b0;
    bus.ce_ = 1'b1; bus.spiclk = 1'b0; bus.mosi = 1'b0;

    repeat (5) @(negedge sysclk);
    check("rst_miso",  bus.miso,      1'b0);
    check("rst_cmd_q", bus.cmd_q,     8'h00);
    check("rst_rcnt",  bus.rst_count, 8'h00);
    check("rst_busy",  bus.busy,      1'b0);
    rst_n = 1'b1;
    repeat (5) @(negedge sysclk);

    for (int i = 0; i < 14; i++) begin
      v = vecs[i];
      run_txn(v.op, v.addr, v.n, (v.op == 8'h02) ? v.data : {$urandom, $urandom}, rd);
      if (v.op == 8'h03 || v.op == 8'h9F)
        for (int unsigned k = 0; k < v.n; k++)
          check($sformatf("vec%0d_byte%0d", i, k), rd[63-8*k -: 8], v.data[63-8*k -: 8]);
      check($sformatf("vec%0d_cmd_q", i), bus.cmd_q, v.exp_cmd);
      check($sformatf("vec%0d_rcnt", i), bus.rst_count, v.exp_rcnt);
    end

    // Aborted write: partial byte must not reach memory.
    run_txn(8'h02, 24'h000020, 1, 64'h7700000000000000, rd);
    cs_low();
    xbyte(8'h02, rb);
    send_addr(24'h000020);
    for (int i = 0; i < 5; i++) xbit(1'b1, rbit);
    cs_high();
    model_op(8'h02);
    run_txn(8'h03, 24'h000020, 1, {$urandom, $urandom}, rd);
    check("abort_keep", rd[63:56], 8'h77);
    run_txn(8'h9F, 24'h000000, 8, {$urandom, $urandom}, rd);
    check("abort_readid", rd, ID_SEQ);

    // ID sequence repeats from MFID after 8 bytes.
    cs_low();
    xbyte(8'h9F, rb);
    send_addr(24'h000000);
    for (int unsigned k = 0; k < 9; k++) begin
      xbyte(8'h00, rb);
      check($sformatf("id_rep%0d", k), rb, ID_SEQ[63-8*(k%8) -: 8]);
    end
    cs_high();
    model_op(8'h9F);

    // Unknown opcode: miso stays low.
    cs_low();
    xbyte(8'hA7, rb);
    xbyte(8'hFF, rb);
    check("ignore_miso", rb, 8'h00);
    cs_high();
    model_op(8'hA7);
    check("ignore_cmd_q", bus.cmd_q, 8'hA7);

    for (int it = 0; it < 30; it++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 3) begin
        op = 8'h02;
        a  = $urandom_range(0, DEPTH - 1);
        last_wa = a;
        n  = $urandom_range(1, 6);
        run_txn(op, {8'($urandom), 4'($urandom), 12'(a)}, n, {$urandom, $urandom}, rd);
      end else if (sel <= 6) begin
        op = 8'h03;
        a  = ($urandom_range(0, 1) == 0) ? last_wa : $urandom_range(0, DEPTH - 1);
        n  = $urandom_range(1, 8);
        run_txn(op, {12'h000, 12'(a)}, n, {$urandom, $urandom}, rd);
        p = a;
        for (int unsigned k = 0; k < n; k++) begin
          if (known[p]) check($sformatf("rand%0d_byte%0d", it, k), rd[63-8*k -: 8], ref_mem[p]);
          p = next_addr(p);
        end
      end else begin
        if (sel == 7) op = 8'h66;
        else if (sel == 8) op = 8'h99;
        else begin
          op = 8'($urandom);
          while (op == 8'h02 || op == 8'h03 || op == 8'h9F || op == 8'h66 || op == 8'h99)
            op = 8'($urandom);
        end
        run_txn(op, 24'h0, 0, 64'h0, rd);
      end
      check($sformatf("rand%0d_cmd_q", it), bus.cmd_q, op);
      check($sformatf("rand%0d_rcnt", it), bus.rst_count, 64'(ref_rcnt));
    end

    // Async reset in the middle of a read while miso is high.
    run_txn(8'h02, 24'h000010, 1, 64'hFF00000000000000, rd);
    run_txn(8'h66, 24'h0, 0, 64'h0, rd);
    run_txn(8'h99, 24'h0, 0, 64'h0, rd);
    check("pre_reset_rcnt", bus.rst_count, 64'(ref_rcnt));
    cs_low();
    xbyte(8'h03, rb);
    send_addr(24'h000010);
    #(HALF / 2);
    check("midread_miso_hi", bus.miso, 1'b1);
    rst_n = 1'b0;
    #1;
    check("areset_miso",  bus.miso,      1'b0);
    check("areset_cmd_q", bus.cmd_q,     8'h00);
    check("areset_busy",  bus.busy,      1'b0);
    check("areset_rcnt",  bus.rst_count, 8'h00);
    bus.ce_ = 1'b1;
    bus.spiclk = 1'b0;
    repeat (4) @(negedge sysclk);
    rst_n = 1'b1;
    ref_rcnt  = 0;
    ref_rsten = 1'b0;
    foreach (known[i]) known[i] = 1'b0;
    repeat (4) @(negedge sysclk);
    check("post_reset_miso", bus.miso, 1'b0);
    run_txn(8'h9F, 24'h000000, 8, {$urandom, $urandom}, rd);
    check("post_reset_id", rd, ID_SEQ);
    check("post_reset_cmd_q", bus.cmd_q, 8'h9F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/psram_spi_target.md
Name: psram_spi_target

Overview:
- SPI-mode-0 target that emulates the command set of an APS6404 PSRAM, for use as the far end of the psram SPI initiator on-chip and in loopback benches.
- Oversamples spiclk, ce_ and mosi on sysclk, decodes opcodes, and backs READ and WRITE with an internal byte-wide synchronous RAM.
- Also answers READID and the RSTEN/RST reset pair.

Parameters:
- DEPTH_LOG2, 12, log2 of memory size in bytes; address bits above it are ignored.
- MFID, 8'h0D, manufacturer ID byte returned by READID.
- KGD, 8'h5D, known-good-die byte returned by READID.
- EID, 48'h123456789ABC, extended ID, returned MSB byte first.

Ports:
- sysclk  in  1  system clock; must be at least 4x spiclk.
- rst_n  in  1  asynchronous, active-low reset.
- spiclk  in  1  SPI clock from the initiator; idles low.
- mosi  in  1  serial data in.
- ce_  in  1  active-low chip enable.
- miso  out  1  serial data out.
- cmd_q  out  8  last complete opcode received.
- rst_count  out  8  count of accepted RSTEN+RST resets; wraps at 255 to 0.
- busy  out  1  high while synchronised ce_ is low.

Behaviour:
- Reset: all outputs are 0. State is IDLE and the rsten flag is clear. RAM contents are undefined.
- Input sync: spiclk, ce_ and mosi each pass through 2-flop synchronisers.
  - A rising edge is sync spiclk 1 with previous value 0; a falling edge is the inverse.
  - mosi is sampled on the sync'd rising edge.
  - miso updates on the sync'd falling edge.
- ce_ high (sync'd), in any state: return to IDLE next cycle, clear the bit counter, discard any partial byte, drive miso 0. A partial write byte is never committed.
- IDLE -> CMD on sync'd ce_ low.
- CMD: shift 8 bits MSB first. On the 8th bit, set cmd_q and decode:
  - 02 -> ADDR (write)
  - 03 -> ADDR (read)
  - 9F -> ADDR (id)
  - 66 -> IGNORE, set rsten
  - 99 -> IGNORE, arm reset if rsten is set
  - other -> IGNORE
- rsten flag:
  - Any completed opcode other than 66 clears rsten.
  - An armed reset takes effect on the ce_ rising edge: rst_count increments and rsten clears.
  - 99 without a preceding 66 has no effect.
- ADDR: shift 24 bits MSB first. The address register keeps the low DEPTH_LOG2 bits.
- Write path: ADDR -> DATA_WR. Each completed 8th bit writes mem[addr] on the following sysclk, then addr increments.
- Read path: ADDR -> DATA_RD.
  - On the rising edge of bit 24, issue a RAM read (1-cycle latency).
  - The first falling edge after that loads the shift register and drives bit 7.
  - Each subsequent falling edge shifts out the next bit.
  - When bit 0 is driven, addr increments and the next byte is prefetched. Bytes stream with no gaps.
- ID path: ADDR -> ID_OUT, with the same timing as DATA_RD.
  - Byte sequence: MFID, KGD, EID[47:40] ... EID[7:0], 8 bytes total.
  - After the 8th byte the sequence repeats from MFID.
- IGNORE: miso is held 0 until ce_ goes high.
- Address increment: modulo 2^DEPTH_LOG2 (linear wrap), unless the optional feature is enabled.
- mosi is ignored during DATA_RD and ID_OUT.
- miso is 0 outside DATA_RD and ID_OUT.

Optional Feature:
- Macro: PSRAM_SPI_TARGET_PAGEWRAP_EN.
- Defined: burst address increments wrap within a 1 KiB page. addr[9:0] increments; the upper bits hold, matching device page-wrap behaviour.
- Undefined: linear increment modulo 2^DEPTH_LOG2.

Test Plan:
- READID: ce_ low, 9F, 24 dummy bits, read 8 bytes -> 0D 5D 12 34 56 78 9A BC. cmd_q = 9F.
- Write/read: WRITE addr 0x000010 with data A5 3C; ce_ high. Then READ addr 0x000010 for 2 bytes -> A5 3C with no gap.
- Reset pair: 66 (ce_ high), then 99 (ce_ high) -> rst_count 0 -> 1.
  - 99 alone -> rst_count unchanged.
  - 66, 02 (ce_ high), then 99 -> rst_count unchanged.
- Abort: WRITE addr 0x20, 5 data bits, ce_ high -> mem[0x20] unchanged. Next READID is answered correctly.
- Wrap, DEPTH_LOG2 = 12: WRITE at 0xFFF with 11 22 -> mem[0xFFF] = 11, mem[0x000] = 22.
  - With the macro defined, WRITE at 0x3FF with 33 44 -> mem[0x3FF] = 33, mem[0x000] = 44.
- Async reset asserted mid READ -> miso 0, cmd_q 0, busy 0 immediately. Block is in IDLE after release.
